toggle_rx: RTL and testbench
============================

TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 Parameter DW, default 8, payload width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on req_tgl; legal values 2..4.
REQ-003 Parameter CNT_W, default 8, width of the accepted-event counter.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-006 Port req_tgl  input  1  request toggle from the initiator; each level change is one event.
REQ-007 Port req_data  input  DW  payload; initiator holds it stable from the req_tgl change until ack_tgl changes.
REQ-008 Port out_valid  output  1  event pending toward the consumer.
REQ-009 Port out_data  output  DW  captured payload; valid while out_valid=1.
REQ-010 Port out_ready  input  1  consumer accepts when out_valid=1 and out_ready=1 at a rising edge.
REQ-011 Port ack_tgl  output  1  acknowledge toggle; changes level once per accepted event.
REQ-012 Port evt_cnt  output  CNT_W  number of accepted events, modulo 2^CNT_W.
REQ-013 Port ovf  output  1  sticky protocol-violation flag.

Function
REQ-014 req_tgl shall pass through a SYNC_STAGES-deep flop chain; the last stage shall be compared with a registered copy (prev) to detect an event (XOR=1).
REQ-015 Latency: a req_tgl change sampled at edge k shall raise out_valid after edge k+SYNC_STAGES (k+2 at default).
REQ-016 FSM states shall be IDLE and VALID only; out_valid=1 exactly in VALID.
REQ-017 IDLE, event detected: go to VALID, capture req_data into out_data on the same edge.
REQ-018 IDLE, out_ready=1 with no event: no effect.
REQ-019 VALID, out_ready=0: hold state; out_data shall not change.
REQ-020 VALID, out_ready=1, no event: on that edge invert ack_tgl, increment evt_cnt, go to IDLE.
REQ-021 VALID, out_ready=1, event detected on the same edge: invert ack_tgl, increment evt_cnt, stay in VALID, capture new req_data; ovf unchanged.
REQ-022 VALID, out_ready=0, event detected: set ovf to 1; drop the new event (no capture, no ack); out_data holds the old value.
REQ-023 evt_cnt shall wrap from 2^CNT_W-1 to 0 without affecting any other output.
REQ-024 ack_tgl shall change only on acceptance; it shall never change twice within SYNC_STAGES+1 cycles of one event.
REQ-025 ovf, once set, shall clear only on reset.

Reset
REQ-026 With reset=0 at a rising edge, all of the following shall hold after that edge: sync chain=0, prev=0, FSM=IDLE, out_valid=0, out_data=0, ack_tgl=0, evt_cnt=0, ovf=0.
REQ-027 Reset asserted while in VALID shall discard the pending event with no ack_tgl change.
REQ-028 The initiator resets req_tgl to 0 in the same reset domain; if req_tgl=1 when reset releases, this block shall report one event per REQ-015.
REQ-029 Event detection shall be inhibited in any cycle with reset=0.

Verification
REQ-030 Basic event, DW=8: reset, req_data=8'hA5, req_tgl 0->1 before edge k, out_ready=1 -> out_valid=1 after edge k+2 with out_data=8'hA5; ack_tgl=1 and evt_cnt=1 after edge k+3; out_valid=0.
REQ-031 Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_valid and out_data held for 5 cycles; ack_tgl and evt_cnt unchanged until out_ready=1.
REQ-032 Overflow: event pending, out_ready=0, req_tgl toggles again -> ovf=1 after detection; out_data keeps the first payload; ovf stays 1 after later acceptances.
REQ-033 Wrap: CNT_W=4, 16 accepted events -> evt_cnt sequence 1..15,0; ack_tgl toggles exactly 16 times and ends at 0.
REQ-034 Reset mid-operation: reset=0 while out_valid=1 -> after that edge out_valid=0, ack_tgl=0, evt_cnt=0, ovf=0; no ack for the discarded event.
REQ-035 Simultaneous accept and new event -> one ack_tgl inversion, evt_cnt +1, out_valid stays 1 with the new payload, ovf=0.

Source files
------------

// File: rtl/toggle_rx.sv
// toggle_rx
//   Receive side of a toggle-handshake clock/reset-domain crossing. The
//   initiator flips req_tgl once per event while holding req_data stable.
//   This block synchronises the toggle, detects each level change, and
//   presents the payload to a valid/ready consumer. It then flips ack_tgl
//   once per accepted event.
//
// Parameters
//   DW          payload width
//   SYNC_STAGES synchronizer depth on req_tgl (2..4)
//   CNT_W       width of the accepted-event counter
//
// Ports
//   clk       sole clock, rising edge
//   reset     synchronous active-low reset
//   req_tgl   request toggle; every level change is one event
//   req_data  payload, stable from req_tgl change until ack_tgl change
//   out_valid event pending toward the consumer
//   out_data  captured payload, valid while out_valid=1
//   out_ready consumer accept (with out_valid at a rising edge)
//   ack_tgl   acknowledge toggle, flips once per accepted event
//   evt_cnt   accepted-event count, wraps modulo 2^CNT_W
//   ovf       sticky flag: an event arrived while one was pending and not
//             being accepted

module toggle_rx #(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_tgl,
  input  logic [DW-1:0]    req_data,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic             ack_tgl,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [DW-1:0]          data_q;
  logic                   ack_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_q;

  logic evt;
  logic capture;
  logic accept;
  logic drop;

  // Next-state and datapath controls
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    drop    = 1'b0;
    // Event = last sync stage differs from its registered copy. It is gated
    // by reset so that nothing is detected in a reset cycle.
    evt     = reset & (sync_q[SYNC_STAGES-1] ^ prev_q);

    unique case (state_q)
      IDLE: begin
        if (evt) begin
          state_d = VALID;
          capture = 1'b1;
        end
      end
      VALID: begin
        if (out_ready) begin
          accept = 1'b1;
          // A new event on the accepting edge is handed over directly:
          // stay in VALID with the fresh payload and no overflow.
          if (evt) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (evt) begin
          // Nowhere to put it: drop the new event and flag the violation.
          drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req_tgl};
      prev_q  <= sync_q[SYNC_STAGES-1];
      if (capture) begin
        data_q <= req_data;
      end
      if (accept) begin
        ack_q <= ~ack_q;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign out_valid = (state_q == VALID);
  assign out_data  = data_q;
  assign ack_tgl   = ack_q;
  assign evt_cnt   = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_toggle_rx.sv
// tb_toggle_rx
//   Directed bench for toggle_rx with DW=8, SYNC_STAGES=2, CNT_W=4. Each
//   step drives inputs 1 time unit after a rising edge. It samples outputs
//   1 time unit after the following edges and compares them against
//   hand-computed values.

module tb_toggle_rx;

  logic       clk;
  logic       reset;
  logic       req_tgl;
  logic [7:0] req_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       ack_tgl;
  logic [3:0] evt_cnt;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int ack_changes = 0;
  logic ack_last = 1'b0;

  toggle_rx #(
    .DW         (8),
    .SYNC_STAGES(2),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_tgl  (req_tgl),
    .req_data (req_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .ack_tgl  (ack_tgl),
    .evt_cnt  (evt_cnt),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (ack_tgl !== ack_last) ack_changes++;
    ack_last = ack_tgl;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_tgl   = 1'b0;
    req_data  = 8'h00;
    out_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'h00);
    chk("rst_ack",   32'(ack_tgl),   32'd0);
    chk("rst_cnt",   32'(evt_cnt),   32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);

    // Basic event: valid after k+2, accepted at k+3
    reset = 1'b1;
    tick();
    req_data  = 8'hA5;
    req_tgl   = 1'b1;
    out_ready = 1'b1;
    tick();                                     // edge k
    chk("basic_k0_valid", 32'(out_valid), 32'd0);
    tick();                                     // k+1
    chk("basic_k1_valid", 32'(out_valid), 32'd0);
    tick();                                     // k+2
    chk("basic_k2_valid", 32'(out_valid), 32'd1);
    chk("basic_k2_data",  32'(out_data),  32'hA5);
    chk("basic_k2_ack",   32'(ack_tgl),   32'd0);
    chk("basic_k2_cnt",   32'(evt_cnt),   32'd0);
    tick();                                     // k+3
    chk("basic_k3_valid", 32'(out_valid), 32'd0);
    chk("basic_k3_ack",   32'(ack_tgl),   32'd1);
    chk("basic_k3_cnt",   32'(evt_cnt),   32'd1);

    // Backpressure: five cycles of out_ready=0 after out_valid rises
    out_ready = 1'b0;
    req_data  = 8'h3C;
    req_tgl   = 1'b0;
    tick(); tick();
    chk("bp_pre_valid", 32'(out_valid), 32'd0);
    tick();
    chk("bp_rise_valid", 32'(out_valid), 32'd1);
    chk("bp_rise_data",  32'(out_data),  32'h3C);
    req_data = 8'h00;                           // must not leak into out_data
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data",  32'(out_data),  32'h3C);
      chk("bp_hold_ack",   32'(ack_tgl),   32'd1);
      chk("bp_hold_cnt",   32'(evt_cnt),   32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_acc_valid", 32'(out_valid), 32'd0);
    chk("bp_acc_ack",   32'(ack_tgl),   32'd0);
    chk("bp_acc_cnt",   32'(evt_cnt),   32'd2);

    // Overflow: second event while first is pending and out_ready=0
    out_ready = 1'b0;
    req_data  = 8'h11;
    req_tgl   = 1'b1;
    tick(); tick(); tick();
    chk("ovf_first_valid", 32'(out_valid), 32'd1);
    chk("ovf_first_data",  32'(out_data),  32'h11);
    req_data = 8'h22;
    req_tgl  = 1'b0;
    tick(); tick();
    chk("ovf_pre_flag", 32'(ovf), 32'd0);
    tick();
    chk("ovf_set_flag", 32'(ovf),       32'd1);
    chk("ovf_set_data", 32'(out_data),  32'h11);
    chk("ovf_set_valid",32'(out_valid), 32'd1);
    chk("ovf_set_ack",  32'(ack_tgl),   32'd0);
    chk("ovf_set_cnt",  32'(evt_cnt),   32'd2);
    out_ready = 1'b1;
    tick();
    chk("ovf_acc_valid", 32'(out_valid), 32'd0);
    chk("ovf_acc_ack",   32'(ack_tgl),   32'd1);
    chk("ovf_acc_cnt",   32'(evt_cnt),   32'd3);
    chk("ovf_sticky",    32'(ovf),       32'd1);
    tick(); tick(); tick();
    chk("ovf_no_extra_valid", 32'(out_valid), 32'd0);
    chk("ovf_no_extra_ack",   32'(ack_tgl),   32'd1);

    // Reset mid-operation discards pending event
    out_ready = 1'b0;
    req_data  = 8'h44;
    req_tgl   = 1'b1;
    tick(); tick(); tick();
    chk("midrst_pre_valid", 32'(out_valid), 32'd1);
    reset   = 1'b0;
    req_tgl = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  32'(out_data),  32'h00);
    chk("midrst_ack",   32'(ack_tgl),   32'd0);
    chk("midrst_cnt",   32'(evt_cnt),   32'd0);
    chk("midrst_ovf",   32'(ovf),       32'd0);
    reset = 1'b1;
    tick(); tick(); tick();
    chk("midrst_after_valid", 32'(out_valid), 32'd0);
    chk("midrst_after_ack",   32'(ack_tgl),   32'd0);

    // Simultaneous accept and new event
    req_data = 8'h55;
    req_tgl  = 1'b1;
    tick(); tick(); tick();
    chk("sim_first_data", 32'(out_data), 32'h55);
    req_data = 8'h66;
    req_tgl  = 1'b0;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    chk("sim_valid", 32'(out_valid), 32'd1);
    chk("sim_data",  32'(out_data),  32'h66);
    chk("sim_ack",   32'(ack_tgl),   32'd1);
    chk("sim_cnt",   32'(evt_cnt),   32'd1);
    chk("sim_ovf",   32'(ovf),       32'd0);
    tick();
    chk("sim_acc2_valid", 32'(out_valid), 32'd0);
    chk("sim_acc2_ack",   32'(ack_tgl),   32'd0);
    chk("sim_acc2_cnt",   32'(evt_cnt),   32'd2);

    // req_tgl=1 at reset release counts as one event
    reset   = 1'b0;
    req_tgl = 1'b1;
    req_data = 8'h01;
    tick();
    chk("rel_rst_valid", 32'(out_valid), 32'd0);
    chk("rel_rst_cnt",   32'(evt_cnt),   32'd0);
    ack_last    = ack_tgl;
    ack_changes = 0;
    reset = 1'b1;
    tick(); tick();
    chk("rel_k1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("rel_k2_valid", 32'(out_valid), 32'd1);
    chk("rel_k2_data",  32'(out_data),  32'h01);
    tick();
    chk("rel_acc_cnt", 32'(evt_cnt), 32'd1);
    chk("rel_acc_ack", 32'(ack_tgl), 32'd1);

    // Counter wrap with CNT_W=4: events 2..16
    for (int i = 2; i <= 16; i++) begin
      req_tgl  = ~req_tgl;
      req_data = 8'(i);
      tick(); tick(); tick();
      chk("wrap_valid", 32'(out_valid), 32'd1);
      chk("wrap_data",  32'(out_data),  32'(i));
      tick();
      chk("wrap_cnt", 32'(evt_cnt), 32'(i % 16));
      chk("wrap_ack", 32'(ack_tgl), 32'(i % 2));
    end
    chk("wrap_ack_toggles", 32'(ack_changes), 32'd16);
    chk("wrap_final_ack",   32'(ack_tgl),     32'd0);
    chk("wrap_final_ovf",   32'(ovf),         32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
